// File: rtl/packet_serializer_if.sv
// Handshake bundle between packet_serializer, its upstream packet FIFO and the downstream flit sink.
// flit_parity is present only when PKT_SER_PARITY_EN is defined.
interface packet_serializer_if #(
  parameter int PACKET_WIDTH = 128,
  parameter int FLIT_WIDTH   = 32
);
  logic                    fifo_empty;
  logic                    fifo_rd_en;
  logic [PACKET_WIDTH-1:0] fifo_rd_data;
  logic                    flit_valid;
  logic                    flit_ready;
  logic [FLIT_WIDTH-1:0]   flit_data;
  logic                    flit_sop;
  logic                    flit_eop;
`ifdef PKT_SER_PARITY_EN
  logic                    flit_parity;
`endif

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    input  flit_ready,
    output fifo_rd_en,
    output flit_valid,
    output flit_data,
    output flit_sop,
`ifdef PKT_SER_PARITY_EN
    output flit_parity,
`endif
    output flit_eop
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    output flit_ready,
    input  fifo_rd_en,
    input  flit_valid,
    input  flit_data,
    input  flit_sop,
`ifdef PKT_SER_PARITY_EN
    input  flit_parity,
`endif
    input  flit_eop
  );
endinterface

// File: rtl/packet_serializer.sv
// Pops wide packets from a FIFO and emits them LSB-first as FLIT_WIDTH flits with sop/eop flags.
// Optional feature macro: PKT_SER_PARITY_EN adds flit_parity (XOR of flit_data).
module packet_serializer #(
  parameter int PACKET_WIDTH = 128,
  parameter int FLIT_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  packet_serializer_if.master        bus,
  output logic                       busy,
  output logic [15:0]                pkt_count
);
  // PACKET_WIDTH must be a multiple of FLIT_WIDTH with at least two flits per packet.
  localparam int NFLITS = PACKET_WIDTH / FLIT_WIDTH;
  localparam int IDX_W  = $clog2(NFLITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NFLITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PACKET_WIDTH-1:0] packet_q, packet_d;
  logic [15:0]             pkt_count_q, pkt_count_d;

  logic                    sending;
  logic                    accept;
  logic                    last_accept;
  logic                    pop;
  logic [FLIT_WIDTH-1:0]   cur_flit;

  // Reset gates every output combinationally so nothing leaks in the reset cycle itself.
  assign sending     = (state_q == SEND) && !rst;
  assign accept      = sending && bus.flit_ready;
  assign last_accept = accept && (idx_q == LAST_IDX);
  assign pop         = !rst && !bus.fifo_empty && ((state_q == IDLE) || last_accept);
  assign cur_flit    = packet_q[int'(idx_q) * FLIT_WIDTH +: FLIT_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      packet_q    <= '0;
      pkt_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      packet_q    <= packet_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    packet_d    = packet_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        packet_d = bus.fifo_rd_data;
        idx_d    = '0;
        state_d  = SEND;
      end
      SEND: begin
        // A pop in the last-accept cycle chains straight into the next FETCH.
        if (last_accept) begin
          pkt_count_d = pkt_count_q + 16'd1;
          state_d     = pop ? FETCH : IDLE;
        end else if (accept) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = SEND;
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.fifo_rd_en = pop;
  assign bus.flit_valid = sending;
  assign bus.flit_data  = sending ? cur_flit : '0;
  assign bus.flit_sop   = sending && (idx_q == '0);
  assign bus.flit_eop   = sending && (idx_q == LAST_IDX);
  assign busy           = !rst && (state_q != IDLE);
  assign pkt_count      = rst ? 16'h0000 : pkt_count_q;

`ifdef PKT_SER_PARITY_EN
  assign bus.flit_parity = sending ? ^cur_flit : 1'b0;
`else
`endif

endmodule

// File: tb/tb_packet_serializer.sv
// Directed bench for packet_serializer: a queue-based FIFO/flit model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_packet_serializer;
  localparam int PW = 128;
  localparam int FW = 32;
  localparam int NF = PW / FW;

  typedef struct packed {
    logic [FW-1:0] data;
    logic          sop;
    logic          eop;
  } flit_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] pkt_count;

  packet_serializer_if #(.PACKET_WIDTH(PW), .FLIT_WIDTH(FW)) bus ();

  packet_serializer #(.PACKET_WIDTH(PW), .FLIT_WIDTH(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            valid_cnt = 0;
  int            mid_stalls = 0;
  logic [PW-1:0] fifo_q[$];
  flit_t         exp_q[$];
  logic [FW-1:0] acc_log[$];
  logic          acc_sop[$];
  logic          acc_eop[$];
  logic          acc_par[$];
  int            acc_cyc[$];
  int            pop_cyc[$];
  logic          pop_seen = 1'b0;
  logic          prev_stall = 1'b0;
  flit_t         prev_flit;
  flit_t         head;
  logic [PW-1:0] fifo_pkt;
  logic [15:0]   done_pkts = 16'h0000;
  logic [15:0]   cnt_offset = 16'h0000;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream FIFO model: a pop seen at the prior negedge delivers the packet after the edge.
  initial begin
    bus.fifo_empty   = 1'b1;
    bus.fifo_rd_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pop_seen && fifo_q.size() != 0) begin
        fifo_pkt = fifo_q.pop_front();
        bus.fifo_rd_data = fifo_pkt;
        for (int k = 0; k < NF; k++)
          exp_q.push_back('{data: fifo_pkt[k*FW +: FW], sop: (k == 0), eop: (k == NF - 1)});
      end
      bus.fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_flit_valid", bus.flit_valid, 1'b0);
      check("rst_flit_sop", bus.flit_sop, 1'b0);
      check("rst_flit_eop", bus.flit_eop, 1'b0);
      check("rst_flit_data", bus.flit_data, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_fifo_rd_en", bus.fifo_rd_en, 1'b0);
      check("rst_pkt_count", pkt_count, 16'h0000);
`ifdef PKT_SER_PARITY_EN
      check("rst_flit_parity", bus.flit_parity, 1'b0);
`endif
      exp_q.delete();
      done_pkts  = 16'h0000;
      prev_stall = 1'b0;
      pop_seen   = 1'b0;
    end else begin
      check("rd_en_while_empty", bus.fifo_rd_en & bus.fifo_empty, 1'b0);
      pop_seen = bus.fifo_rd_en;
      if (bus.fifo_rd_en) pop_cyc.push_back(cyc);
      check("pkt_count", pkt_count, 16'(cnt_offset + done_pkts));
      if (bus.flit_valid) begin
        valid_cnt++;
        check("busy_while_valid", busy, 1'b1);
        if (prev_stall) begin
          check("hold_data", bus.flit_data, prev_flit.data);
          check("hold_sop", bus.flit_sop, prev_flit.sop);
          check("hold_eop", bus.flit_eop, prev_flit.eop);
        end
        if (exp_q.size() == 0) begin
          check("unexpected_flit", bus.flit_valid, 1'b0);
        end else begin
          head = exp_q[0];
          check("flit_data", bus.flit_data, head.data);
          check("flit_sop", bus.flit_sop, head.sop);
          check("flit_eop", bus.flit_eop, head.eop);
`ifdef PKT_SER_PARITY_EN
          check("flit_parity", bus.flit_parity, ^head.data);
`endif
          if (bus.flit_ready) begin
            void'(exp_q.pop_front());
            if (head.eop) done_pkts = done_pkts + 16'd1;
          end
        end
        if (bus.flit_ready) begin
          acc_log.push_back(bus.flit_data);
          acc_sop.push_back(bus.flit_sop);
          acc_eop.push_back(bus.flit_eop);
          acc_cyc.push_back(cyc);
`ifdef PKT_SER_PARITY_EN
          acc_par.push_back(bus.flit_parity);
`else
          acc_par.push_back(^bus.flit_data);
`endif
        end else if (!bus.flit_sop) begin
          mid_stalls++;
        end
      end else if (prev_stall) begin
        check("valid_dropped_under_stall", bus.flit_valid, 1'b1);
      end
      prev_stall = bus.flit_valid && !bus.flit_ready;
      prev_flit  = '{data: bus.flit_data, sop: bus.flit_sop, eop: bus.flit_eop};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_flits(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (acc_log.size() >= n) break;
      sample();
    end
    check("wait_flits_timeout", acc_log.size() >= n, 1'b1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.flit_valid) break;
      sample();
    end
    check("wait_valid_timeout", bus.flit_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [PW-1:0] p1;
  logic [PW-1:0] p3[3];
  logic [FW-1:0] lit1[4];
  int            b, p0, vc0, ms0, push_cyc;

  initial begin
    p1      = 128'h44444444_33333333_22222222_11111111;
    p3[0]   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    p3[1]   = 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000;
    p3[2]   = 128'h13579BDF_2468ACE0_CAFEF00D_DEADBEEF;
    lit1[0] = 32'h11111111;
    lit1[1] = 32'h22222222;
    lit1[2] = 32'h33333333;
    lit1[3] = 32'h44444444;

    rst = 1'b1;
    bus.flit_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    sample();
    check("idle_busy", busy, 1'b0);
    check("idle_pkt_count", pkt_count, 16'h0000);
    check("idle_rd_en", bus.fifo_rd_en, 1'b0);

    // Single packet with the sink always ready.
    tick();
    bus.flit_ready = 1'b1;
    b = acc_log.size();
    p0 = pop_cyc.size();
    fifo_q.push_back(p1);
    wait_flits(b + 4, 30);
    for (int k = 0; k < 4; k++) begin
      check("t1_flit", acc_log[b+k], lit1[k]);
      check("t1_sop", acc_sop[b+k], (k == 0));
      check("t1_eop", acc_eop[b+k], (k == 3));
    end
    check("t1_pop_to_first_flit", acc_cyc[b] - pop_cyc[p0], 2);
    check("t1_consecutive", acc_cyc[b+3] - acc_cyc[b], 3);
    sample();
    check("t1_pkt_count", pkt_count, 16'd1);
    check("t1_pops", pop_cyc.size() - p0, 1);

    // Backpressure for three cycles on the second flit.
    tick();
    bus.flit_ready = 1'b0;
    b = acc_log.size();
    p0 = pop_cyc.size();
    ms0 = mid_stalls;
    fifo_q.push_back(p1);
    wait_valid(20);
    tick();
    bus.flit_ready = 1'b1;
    tick();
    bus.flit_ready = 1'b0;
    repeat (3) tick();
    bus.flit_ready = 1'b1;
    wait_flits(b + 4, 30);
    for (int k = 0; k < 4; k++) check("t2_flit", acc_log[b+k], lit1[k]);
    check("t2_stall_cycles", mid_stalls - ms0, 3);
    check("t2_pops", pop_cyc.size() - p0, 1);

    // Three packets back to back.
    tick();
    b = acc_log.size();
    p0 = pop_cyc.size();
    for (int k = 0; k < 3; k++) fifo_q.push_back(p3[k]);
    wait_flits(b + 12, 60);
    check("t3_pops", pop_cyc.size() - p0, 3);
    check("t3_first_flit_latency", acc_cyc[b] - pop_cyc[p0], 2);
    check("t3_span", acc_cyc[b+11] - pop_cyc[p0], 15);
    check("t3_flit5", acc_log[b+4], 32'h00000000);
    check("t3_flit12", acc_log[b+11], 32'h13579BDF);
    sample();
    check("t3_pkt_count", pkt_count, 16'd5);

    // Reset while the first flit is stalled on the bus.
    tick();
    bus.flit_ready = 1'b0;
    fifo_q.push_back(128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    wait_valid(20);
    tick();
    rst = 1'b1;
    sample();
    check("t4_valid_in_reset", bus.flit_valid, 1'b0);
    tick();
    rst = 1'b0;
    bus.flit_ready = 1'b1;
    sample();
    check("t4_pkt_count_cleared", pkt_count, 16'h0000);
    vc0 = valid_cnt;
    p0 = pop_cyc.size();
    repeat (10) sample();
    check("t4_no_flits_after_reset", valid_cnt - vc0, 0);
    check("t4_no_pops_after_reset", pop_cyc.size() - p0, 0);

    // Counter wrap: preload stands in for 65535 completed packets.
    tick();
    force dut.pkt_count_q = 16'hFFFF;
    cnt_offset = 16'hFFFF;
    sample();
    check("t5_preload", pkt_count, 16'hFFFF);
    tick();
    release dut.pkt_count_q;
    sample();
    check("t5_preload_held", pkt_count, 16'hFFFF);
    tick();
    b = acc_log.size();
    p0 = pop_cyc.size();
    push_cyc = cyc;
    fifo_q.push_back(p3[1]);
    wait_flits(b + 4, 30);
    check("t5_first_pop_cycle", pop_cyc[p0], push_cyc);
    sample();
    check("t5_pkt_count_wrap", pkt_count, 16'h0000);

`ifdef PKT_SER_PARITY_EN
    tick();
    b = acc_log.size();
    fifo_q.push_back(128'h00000000_00000000_00000003_00000007);
    wait_flits(b + 4, 30);
    check("t6_flit_7", acc_log[b], 32'h00000007);
    check("t6_parity_7", acc_par[b], 1'b1);
    check("t6_flit_3", acc_log[b+1], 32'h00000003);
    check("t6_parity_3", acc_par[b+1], 1'b0);
`endif

    repeat (2) sample();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/packet_serializer.md
PACKET_SERIALIZER -- requirements
Module: packet_serializer

Interface
REQ-001 The block SHALL have parameter PACKET_WIDTH, default 128, which is the width of the packet word read from the upstream packet FIFO.
REQ-002 The block SHALL have parameter FLIT_WIDTH, default 32, which is the width of one outbound flit.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit: the upstream FIFO holds no packet.
REQ-006 The block SHALL have port fifo_rd_en, output, 1 bit: pop request to the upstream FIFO.
REQ-007 The block SHALL have port fifo_rd_data, input, PACKET_WIDTH bits: popped packet, valid exactly one cycle after an accepted pop.
REQ-008 The block SHALL have port flit_valid, output, 1 bit: flit_data and its flags are valid.
REQ-009 The block SHALL have port flit_ready, input, 1 bit: the downstream stage accepts the flit.
REQ-010 The block SHALL have port flit_data, output, FLIT_WIDTH bits: the current flit.
REQ-011 The block SHALL have port flit_sop, output, 1 bit: the current flit is the first of its packet.
REQ-012 The block SHALL have port flit_eop, output, 1 bit: the current flit is the last of its packet.
REQ-013 The block SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-014 The block SHALL have port pkt_count, output, 16 bits: count of fully sent packets.

Function
REQ-015 NFLITS SHALL be PACKET_WIDTH/FLIT_WIDTH; PACKET_WIDTH SHALL be an integer multiple of FLIT_WIDTH, and NFLITS SHALL be at least 2.
REQ-016 The FSM SHALL have states IDLE, FETCH and SEND.
REQ-017 fifo_rd_en SHALL be a combinational output, high only when (state==IDLE, or state==SEND with the last flit accepted this cycle), fifo_empty==0 and rst==0.
REQ-018 IDLE SHALL go to FETCH when fifo_rd_en is high, and SHALL otherwise stay in IDLE.
REQ-019 FETCH SHALL last exactly one cycle, load fifo_rd_data into the packet register, clear the flit index, and go to SEND.
REQ-020 In SEND, flit_valid SHALL be 1 and flit_data SHALL be packet[idx*FLIT_WIDTH +: FLIT_WIDTH], sent LSB slice first.
REQ-021 flit_sop SHALL equal (idx==0) and flit_eop SHALL equal (idx==NFLITS-1), both gated by flit_valid.
REQ-022 While flit_valid==1 and flit_ready==0, flit_data, flit_sop and flit_eop SHALL hold stable.
REQ-023 On flit_valid and flit_ready with idx<NFLITS-1, idx SHALL increment.
REQ-024 On flit_valid and flit_ready with idx==NFLITS-1, pkt_count SHALL increment (wrapping 0xFFFF to 0x0000), and the state SHALL go to FETCH if fifo_rd_en is high, otherwise to IDLE.
REQ-025 Back-to-back packets SHALL cost NFLITS+1 cycles each when flit_ready is held high: one FETCH bubble per packet.
REQ-026 fifo_rd_en SHALL never be asserted while fifo_empty==1.

Reset
REQ-027 While rst is high, the block SHALL force state=IDLE, idx=0, packet register=0, pkt_count=0, and drive flit_valid=0, flit_sop=0, flit_eop=0, busy=0, fifo_rd_en=0 and flit_data=0.
REQ-028 A reset asserted mid-packet SHALL discard the remaining flits, and no further flit of that packet SHALL appear after rst deasserts.
REQ-029 After rst deasserts, the first pop SHALL occur in the first cycle in which fifo_empty==0.

Configuration
REQ-030 When macro PKT_SER_PARITY_EN is defined, the block SHALL add output flit_parity, 1 bit, equal to the XOR reduction of flit_data, 0 in reset, and held stable under backpressure like flit_data.
REQ-031 When PKT_SER_PARITY_EN is undefined, the flit_parity port SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL cover: defaults, one packet 0x44444444_33333333_22222222_11111111, flit_ready=1 -> flits 0x11111111 (sop), 0x22222222, 0x33333333, 0x44444444 (eop) on consecutive cycles, pop-to-first-flit 2 cycles, pkt_count=1.
REQ-033 The bench SHALL cover: flit_ready low for 3 cycles on flit 2 -> flit_data stays 0x22222222 with valid high, no extra pop, order preserved.
REQ-034 The bench SHALL cover: 3 packets queued, flit_ready=1 -> 12 flits in 15 cycles, exactly 3 pops, pkt_count=3, fifo_rd_en never high with fifo_empty high.
REQ-035 The bench SHALL cover: rst high during flit 1 of a packet -> next cycle flit_valid=0, pkt_count=0; after release with the FIFO empty, no flits appear.
REQ-036 The bench SHALL cover: pkt_count preloaded by sending 65535 packets, then one more -> pkt_count=0x0000.
REQ-037 The bench SHALL cover: with PKT_SER_PARITY_EN defined, flit 0x00000007 -> flit_parity=1, and flit 0x00000003 -> flit_parity=0.
